// File: rtl/combo_lock_pkg.sv
// -----------------------------------------------------------------------------
// combo_lock_pkg
//   Shared types and constants for the combination-lock controller.
//   - state_e   : controller state encoding
//   - SEL_*     : display mode codes driven on the Select output
//   - max3 / timer_width : helpers that size the shared hold/timeout counter
//
// Build option: define COMBO_LOCK_LOCKOUT_EN to add the LOCKOUT state.
// -----------------------------------------------------------------------------
package combo_lock_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
`ifdef COMBO_LOCK_LOCKOUT_EN
    , ST_LOCKOUT
`endif
  } state_e;

  // Display mode codes. ENTRY uses pos+1 (001..100) and so has no constant.
  localparam logic [2:0] SEL_LOCK = 3'b000;
  localparam logic [2:0] SEL_WAIT = 3'b101;  // CHECK and LOCKOUT
  localparam logic [2:0] SEL_PASS = 3'b110;
  localparam logic [2:0] SEL_FAIL = 3'b111;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The timer is loaded with N-1 and counts to zero, so $clog2(N) bits hold
  // the largest load. Never return a zero-width counter.
  function automatic int unsigned timer_width(input int unsigned longest);
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
//   Registers a synchronous level and flags its 0->1 transition for one cycle.
//   A level held high produces a single pulse.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (clears the history register)
//   level  in   synchronous, debounced level
//   rise   out  high for the cycle in which level is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/combo_lock_ctrl.sv
// -----------------------------------------------------------------------------
// combo_lock_ctrl
//   Four-digit combination lock. The user wakes the lock with Enter, keys four
//   digits (one per Enter press), and the stored value is compared with CODE.
//   A match unlocks until Clear; a mismatch shows FAIL for a fixed time.
//   With COMBO_LOCK_LOCKOUT_EN defined, MAX_TRIES consecutive mismatches lead
//   to a LOCKOUT period with Alarm asserted.
//
// Parameters
//   CODE            secret code, [15:12] first digit ... [3:0] last digit
//   MAX_TRIES       consecutive failures before lockout
//   TIMEOUT_CYCLES  idle cycles tolerated during entry before aborting
//   FAIL_CYCLES     FAIL display hold time
//   LOCKOUT_CYCLES  lockout hold time
//
// Ports
//   CLK       in   system clock, all state changes on its rising edge
//   RST_N     in   asynchronous active-low reset
//   Enter     in   debounced button level; only its rising edge acts
//   Clear     in   debounced button level
//   Digit     in   [3:0] switch value for the current digit
//   Select    out  [2:0] display mode code for the seven-segment driver
//   Number    out  [3:0] digit shown (live Digit during entry, else 0)
//   Unlocked  out  high while in PASS
//   Alarm     out  high while in LOCKOUT (tied 0 without the lockout option)
//
// Build option: COMBO_LOCK_LOCKOUT_EN enables the fail counter and LOCKOUT.
// -----------------------------------------------------------------------------
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned FAIL_CYCLES    = 200_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Enter,
  input  logic       Clear,
  input  logic [3:0] Digit,
  output logic [2:0] Select,
  output logic [3:0] Number,
  output logic       Unlocked,
  output logic       Alarm
);

  // One down-counter serves the entry timeout and both hold times.
  localparam int unsigned TIMER_W =
    timer_width(max3(TIMEOUT_CYCLES, FAIL_CYCLES, LOCKOUT_CYCLES));

  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] FAIL_LOAD    = TIMER_W'(FAIL_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           pos_q, pos_d;
  logic [15:0]          code_q, code_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 enter_rise;

`ifdef COMBO_LOCK_LOCKOUT_EN
  localparam int unsigned        FAIL_W       = $clog2(MAX_TRIES + 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX     = FAIL_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  logic [FAIL_W-1:0] fail_q, fail_d;
`else
  // Without lockout the try limit has no effect on the logic.
  logic unused_max_tries;
  assign unused_max_tries = (MAX_TRIES != 0);
`endif

  // ---------------------------------------------------------------------------
  // Enter edge detection
  // ---------------------------------------------------------------------------
  edge_detect u_enter_edge (
    .clk   (CLK),
    .rst_n (RST_N),
    .level (Enter),
    .rise  (enter_rise)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: the four stored digits are a plain register, not a RAM, so they are
  // reset like any other flop; a RAM array would normally be left unreset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_LOCKED;
      pos_q   <= 2'd0;
      code_q  <= 16'h0000;
      timer_q <= '0;
`ifdef COMBO_LOCK_LOCKOUT_EN
      fail_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      code_q  <= code_d;
      timer_q <= timer_d;
`ifdef COMBO_LOCK_LOCKOUT_EN
      fail_q  <= fail_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold-value default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    code_d  = code_q;
    timer_d = timer_q;
`ifdef COMBO_LOCK_LOCKOUT_EN
    fail_d  = fail_q;
`endif

    unique case (state_q)
      ST_LOCKED: begin
        // Wake-up press captures nothing; Clear suppresses it.
        if (enter_rise && !Clear) begin
          state_d = ST_ENTRY;
          pos_d   = 2'd0;
          code_d  = 16'h0000;
          timer_d = TIMEOUT_LOAD;
        end
      end

      ST_ENTRY: begin
        if (Clear) begin
          // Clear has priority over a simultaneous Enter edge.
          state_d = ST_LOCKED;
          pos_d   = 2'd0;
          code_d  = 16'h0000;
          timer_d = '0;
        end else if (enter_rise) begin
          unique case (pos_q)
            2'd0:    code_d[15:12] = Digit;
            2'd1:    code_d[11:8]  = Digit;
            2'd2:    code_d[7:4]   = Digit;
            default: code_d[3:0]   = Digit;
          endcase
          // pos wraps 3 -> 0 on the last capture, ready for the next attempt.
          pos_d   = pos_q + 2'd1;
          timer_d = TIMEOUT_LOAD;
          if (pos_q == 2'd3) begin
            state_d = ST_CHECK;
          end
        end else if (timer_q == '0) begin
          state_d = ST_LOCKED;
          pos_d   = 2'd0;
          code_d  = 16'h0000;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      ST_CHECK: begin
        // Stored digits are dropped once compared.
        code_d = 16'h0000;
        if (code_q == CODE) begin
          state_d = ST_PASS;
`ifdef COMBO_LOCK_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          state_d = ST_FAIL;
          timer_d = FAIL_LOAD;
`ifdef COMBO_LOCK_LOCKOUT_EN
          fail_d  = (fail_q == FAIL_MAX) ? fail_q : fail_q + FAIL_W'(1);
`endif
        end
      end

      ST_PASS: begin
        if (Clear) begin
          state_d = ST_LOCKED;
        end
      end

      ST_FAIL: begin
        if (timer_q == '0) begin
`ifdef COMBO_LOCK_LOCKOUT_EN
          if (fail_q == FAIL_MAX) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCKOUT_LOAD;
          end else begin
            state_d = ST_LOCKED;
          end
`else
          state_d = ST_LOCKED;
`endif
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

`ifdef COMBO_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_LOCKED;
        pos_d   = 2'd0;
        code_d  = 16'h0000;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the current state only (Number also passes Digit
  // through live during entry), so reset forces them low immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    Select   = SEL_LOCK;
    Number   = 4'h0;
    Unlocked = 1'b0;

    unique case (state_q)
      ST_ENTRY: begin
        Select = {1'b0, pos_q} + 3'd1;
        Number = Digit;
      end
      ST_CHECK: Select = SEL_WAIT;
      ST_PASS: begin
        Select   = SEL_PASS;
        Unlocked = 1'b1;
      end
      ST_FAIL:  Select = SEL_FAIL;
`ifdef COMBO_LOCK_LOCKOUT_EN
      ST_LOCKOUT: Select = SEL_WAIT;
`endif
      default: ;
    endcase
  end

`ifdef COMBO_LOCK_LOCKOUT_EN
  assign Alarm = (state_q == ST_LOCKOUT);
`else
  assign Alarm = 1'b0;
`endif

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_combo_lock_ctrl
//   Self-checking bench for combo_lock_ctrl with CODE=16'h1234, MAX_TRIES=3,
//   TIMEOUT_CYCLES=100, FAIL_CYCLES=20, LOCKOUT_CYCLES=50.
//   Each stimulus cycle pushes the outputs expected after the next clock edge
//   onto a scoreboard queue; they are popped and compared 1 time unit after
//   that edge. Expectations adapt to the COMBO_LOCK_LOCKOUT_EN build option.
// -----------------------------------------------------------------------------
module tb_combo_lock_ctrl;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       Enter = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] Digit = 4'h0;
  logic [2:0] Select;
  logic [3:0] Number;
  logic       Unlocked;
  logic       Alarm;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string      tag;
    logic [2:0] sel;
    logic [3:0] num;
    logic       unl;
    logic       alm;
  } exp_t;

  exp_t sb[$];

  combo_lock_ctrl #(
    .CODE           (16'h1234),
    .MAX_TRIES      (3),
    .TIMEOUT_CYCLES (100),
    .FAIL_CYCLES    (20),
    .LOCKOUT_CYCLES (50)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Enter    (Enter),
    .Clear    (Clear),
    .Digit    (Digit),
    .Select   (Select),
    .Number   (Number),
    .Unlocked (Unlocked),
    .Alarm    (Alarm)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic score();
    exp_t x;
    x = sb.pop_front();
    check({x.tag, ".sel"}, 32'(Select),   32'(x.sel));
    check({x.tag, ".num"}, 32'(Number),   32'(x.num));
    check({x.tag, ".unl"}, 32'(Unlocked), 32'(x.unl));
    check({x.tag, ".alm"}, 32'(Alarm),    32'(x.alm));
  endtask

  // Drive inputs for one cycle and queue the outputs expected after the edge.
  // Number is expected to follow Digit only in the ENTRY codes 001..100.
  task automatic step(input logic e, input logic c, input logic [3:0] d,
                      input string tag, input logic [2:0] sel,
                      input logic unl, input logic alm);
    exp_t x;
    Enter = e;
    Clear = c;
    Digit = d;
    x.tag = tag;
    x.sel = sel;
    x.num = (sel >= 3'd1 && sel <= 3'd4) ? d : 4'h0;
    x.unl = unl;
    x.alm = alm;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    score();
  endtask

  // Wake, key four digits, end one cycle after CHECK in PASS or FAIL.
  task automatic enter_code(input logic [15:0] code, input bit good,
                            input string tag);
    logic [3:0] d;
    step(1'b1, 1'b0, 4'h0, {tag, ".wake"},     3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, {tag, ".wake_rel"}, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d = code[15-4*i -: 4];
      step(1'b1, 1'b0, d, {tag, ".dig"},     3'(i + 2), 1'b0, 1'b0);
      step(1'b0, 1'b0, d, {tag, ".dig_rel"}, 3'(i + 2), 1'b0, 1'b0);
    end
    d = code[3:0];
    step(1'b1, 1'b0, d, {tag, ".check"}, 3'b101, 1'b0, 1'b0);
    if (good) step(1'b0, 1'b0, d, {tag, ".pass"}, 3'b110, 1'b1, 1'b0);
    else      step(1'b0, 1'b0, d, {tag, ".fail"}, 3'b111, 1'b0, 1'b0);
  endtask

  // Wrong code, 20 FAIL cycles (an ignored Enter press inside), then exit.
  task automatic bad_code(input string tag, input bit to_lockout);
    enter_code(16'h1235, 1'b0, tag);
    for (int i = 1; i < 20; i++) begin
      step((i == 5), 1'b0, 4'h0, {tag, ".fail_hold"}, 3'b111, 1'b0, 1'b0);
    end
    if (to_lockout) step(1'b0, 1'b0, 4'h0, {tag, ".to_lockout"}, 3'b101, 1'b0, 1'b1);
    else            step(1'b0, 1'b0, 4'h0, {tag, ".to_locked"},  3'b000, 1'b0, 1'b0);
  endtask

  task automatic clear_pass(input string tag);
    step(1'b0, 1'b1, 4'h0, {tag, ".clear"}, 3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, {tag, ".idle"},  3'b000, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must drop at once.
  task automatic reset_pulse(input string tag);
    Enter = 1'b0;
    Clear = 1'b0;
    Digit = 4'h9;
    #3;
    RST_N = 1'b0;
    #1;
    check({tag, ".sel"}, 32'(Select),   32'(3'b000));
    check({tag, ".num"}, 32'(Number),   32'(4'h0));
    check({tag, ".unl"}, 32'(Unlocked), 32'(1'b0));
    check({tag, ".alm"}, 32'(Alarm),    32'(1'b0));
    @(posedge CLK);
    #1;
    check({tag, ".held_sel"}, 32'(Select), 32'(3'b000));
    RST_N = 1'b1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    Digit = 4'h9;
    #13;
    check("rst.sel", 32'(Select),   32'(3'b000));
    check("rst.num", 32'(Number),   32'(4'h0));
    check("rst.unl", 32'(Unlocked), 32'(1'b0));
    check("rst.alm", 32'(Alarm),    32'(1'b0));
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    step(1'b0, 1'b0, 4'h9, "idle", 3'b000, 1'b0, 1'b0);

    // ---------------- correct code, PASS holds until Clear ----------------
    enter_code(16'h1234, 1'b1, "ok1");
    for (int i = 0; i < 4; i++) begin
      step((i == 1), 1'b0, 4'h0, "pass_hold", 3'b110, 1'b1, 1'b0);
    end
    clear_pass("ok1");

    // ---------------- wrong codes ----------------
`ifdef COMBO_LOCK_LOCKOUT_EN
    bad_code("bad1", 1'b0);
    bad_code("bad2", 1'b0);
    bad_code("bad3", 1'b1);
    // LOCKOUT: 50 cycles, Enter and Clear ignored.
    for (int i = 1; i < 50; i++) begin
      step((i == 10 || i == 30), (i == 20), 4'h0, "lockout_hold",
           3'b101, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 4'h0, "lockout_exit", 3'b000, 1'b0, 1'b0);
    // Counter was cleared on lockout exit; a match clears it too.
    bad_code("cnt1", 1'b0);
    bad_code("cnt2", 1'b0);
    enter_code(16'h1234, 1'b1, "cnt_ok");
    clear_pass("cnt_ok");
    bad_code("cnt3", 1'b0);
    bad_code("cnt4", 1'b0);
    bad_code("cnt5", 1'b1);
    // Reset in the middle of LOCKOUT leaves no residual count.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'h0, "lockout2_hold", 3'b101, 1'b0, 1'b1);
    end
    reset_pulse("rst_lockout");
    bad_code("post_rst", 1'b0);
`else
    for (int n = 0; n < 5; n++) begin
      bad_code("bad", 1'b0);
    end
    enter_code(16'h1235, 1'b0, "rst_fail");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'h0, "rst_fail.hold", 3'b111, 1'b0, 1'b0);
    end
    reset_pulse("rst_fail");
    bad_code("post_rst", 1'b0);
`endif

    // ---------------- held Enter counts once ----------------
    step(1'b1, 1'b0, 4'h0, "held.wake",     3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, "held.wake_rel", 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 4'h1, "held.enter", 3'd2, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 4'h1, "held.rel",  3'd2,   1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h2, "held.d2",   3'd3,   1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h2, "held.d2r",  3'd3,   1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h3, "held.d3",   3'd4,   1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h3, "held.d3r",  3'd4,   1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h4, "held.chk",  3'b101, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h4, "held.pass", 3'b110, 1'b1, 1'b0);
    clear_pass("held");

    // ---------------- Clear beats a simultaneous Enter edge ----------------
    step(1'b1, 1'b1, 4'h0, "ce.locked",     3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, "ce.locked_rel", 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h0, "ce.wake",       3'd1,   1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, "ce.wake_rel",   3'd1,   1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h1, "ce.d1",         3'd2,   1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h1, "ce.d1r",        3'd2,   1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h2, "ce.both",       3'b000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h2, "ce.after",      3'b000, 1'b0, 1'b0);

    // ---------------- entry timeout, restarted by each capture ----------------
    step(1'b1, 1'b0, 4'h0, "to.wake",     3'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, "to.wake_rel", 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 4'h1, "to.d1",       3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 49; i++) begin
      step(1'b0, 1'b0, 4'h1, "to.gap", 3'd2, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 4'h2, "to.d2", 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) begin
      step(1'b0, 1'b0, 4'h2, "to.idle", 3'd3, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 4'h2, "to.expired", 3'b000, 1'b0, 1'b0);
    enter_code(16'h1234, 1'b1, "to_ok");
    clear_pass("to_ok");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
